// File: rtl/charge_accumulator.sv
// Read-modify-write front end for the neuron charge RAM: accumulates signed
// synaptic weights with saturation, fires on threshold and owns RAM clearing.
module charge_accumulator #(
  parameter int ADDR_W   = 8,
  parameter int CHARGE_W = 16,
  parameter int WEIGHT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [WEIGHT_W-1:0] in_weight,
  input  logic [CHARGE_W-1:0] threshold,
  input  logic                clear,
  output logic                clear_busy,
  output logic                fire_valid,
  input  logic                fire_ready,
  output logic [ADDR_W-1:0]   fire_addr,
  output logic [ADDR_W-1:0]   ram_rd_addr,
  output logic                ram_rd_en,
  input  logic [CHARGE_W-1:0] ram_rd_data,
  output logic [ADDR_W-1:0]   ram_wr_addr,
  output logic                ram_wr_en,
  output logic [CHARGE_W-1:0] ram_wr_data
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic signed [CHARGE_W-1:0] CHARGE_MAX = {1'b0, {(CHARGE_W-1){1'b1}}};
  localparam logic signed [CHARGE_W-1:0] CHARGE_MIN = {1'b1, {(CHARGE_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0]          LAST_ADDR  = '1;

  state_t                      state, state_next;
  logic [ADDR_W-1:0]           clr_addr, clr_addr_next;
  logic                        clr_pending, clr_pending_next;

  logic                        s1_valid;
  logic [ADDR_W-1:0]           s1_addr;
  logic signed [WEIGHT_W-1:0]  s1_weight;
  logic                        s1_fwd;
  logic signed [CHARGE_W-1:0]  s1_fwd_val;

  logic signed [CHARGE_W-1:0]  operand, sat_sum, s1_wdata;
  logic signed [CHARGE_W:0]    sum;
  logic                        s1_fire, stall, s1_write, accept, fwd_hit;

  // Stage-1 arithmetic: 17-bit sum, clamp on overflow, signed threshold compare.
  always_comb begin
    operand = s1_fwd ? s1_fwd_val : $signed(ram_rd_data);
    sum     = {operand[CHARGE_W-1], operand}
            + {{(CHARGE_W+1-WEIGHT_W){s1_weight[WEIGHT_W-1]}}, s1_weight};
    if (sum[CHARGE_W] != sum[CHARGE_W-1])
      sat_sum = sum[CHARGE_W] ? CHARGE_MIN : CHARGE_MAX;
    else
      sat_sum = sum[CHARGE_W-1:0];
    s1_fire  = (sat_sum >= $signed(threshold));
    s1_wdata = s1_fire ? '0 : sat_sum;
  end

  // A fire that cannot be handed off freezes stage 1, which in turn blocks intake.
  assign stall      = s1_valid & s1_fire & fire_valid & ~fire_ready;
  assign s1_write   = s1_valid & ~stall & ~reset;
  assign in_ready   = (state == RUN) & ~clr_pending & ~stall & ~reset;
  assign accept     = in_valid & in_ready;
  assign fwd_hit    = s1_write & (s1_addr == in_addr);
  assign clear_busy = (state == CLEAR) | clr_pending;
  assign ram_rd_addr = in_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      clr_addr    <= '0;
      clr_pending <= 1'b0;
    end else begin
      // NOTE: all sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of block evaluation order.
      state       <= state_next;
      clr_addr    <= clr_addr_next;
      clr_pending <= clr_pending_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_next       = state;
    clr_addr_next    = clr_addr;
    clr_pending_next = clr_pending;
    ram_rd_en        = accept;
    ram_wr_en        = s1_write;
    ram_wr_addr      = s1_addr;
    ram_wr_data      = s1_wdata;
    case (state)
      CLEAR: begin
        ram_wr_en        = ~reset;
        ram_wr_addr      = clr_addr;
        ram_wr_data      = '0;
        clr_pending_next = 1'b0;
        if (clear) begin
          clr_addr_next = '0;
        end else if (clr_addr == LAST_ADDR) begin
          state_next    = RUN;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr + 1'b1;
        end
      end
      RUN: begin
        if (clear) clr_pending_next = 1'b1;
        // Stage 1 empty implies no stall, so the sweep cannot clobber a live event.
        if (clr_pending && !s1_valid) begin
          state_next       = CLEAR;
          clr_addr_next    = '0;
          clr_pending_next = 1'b0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      fire_valid <= 1'b0;
      fire_addr  <= '0;
    end else begin
      if (!stall) s1_valid <= accept;
      if (s1_write && s1_fire) begin
        fire_valid <= 1'b1;
        fire_addr  <= s1_addr;
      end else if (fire_ready) begin
        fire_valid <= 1'b0;
      end
    end
  end

  // NOTE: stage-1 payload is qualified by s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_addr    <= in_addr;
      s1_weight  <= in_weight;
      s1_fwd     <= fwd_hit;
      s1_fwd_val <= s1_wdata;
    end
  end

endmodule

// File: tb/tb_charge_accumulator.sv
// Self-checking bench for charge_accumulator: behavioural RAM, table vectors,
// corner-case sequences and randomized events against an arithmetic model.
`timescale 1ns/1ps
module tb_charge_accumulator;

  logic        clk = 1'b0;
  logic        reset, in_valid, clear, fire_ready;
  logic        in_ready, clear_busy, fire_valid, ram_rd_en, ram_wr_en;
  logic [7:0]  in_addr, in_weight, fire_addr, ram_rd_addr, ram_wr_addr;
  logic [15:0] threshold, ram_rd_data, ram_wr_data;

  always #5 clk = ~clk;

  charge_accumulator dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_weight(in_weight), .threshold(threshold),
    .clear(clear), .clear_busy(clear_busy), .fire_valid(fire_valid),
    .fire_ready(fire_ready), .fire_addr(fire_addr),
    .ram_rd_addr(ram_rd_addr), .ram_rd_en(ram_rd_en), .ram_rd_data(ram_rd_data),
    .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data)
  );

  // Dual-port RAM: registered read returning pre-write contents, data held while idle.
  logic signed [15:0] mem [256];
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  end

  typedef struct {
    int addr;
    int weight;
    int thr;
    int exp_wdata;
    bit exp_fire;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;
  int thr;
  int ch [256];
  int exp_fire_q [$];
  int fire_q [$];
  int wl_addr [$];
  int wl_data [$];
  bit log_en     = 1'b0;
  bit rand_ready = 1'b0;

  always @(negedge clk) begin
    if (fire_valid && fire_ready) fire_q.push_back(int'(fire_addr));
    if (log_en && ram_wr_en) begin
      wl_addr.push_back(int'(ram_wr_addr));
      wl_data.push_back(int'($signed(ram_wr_data)));
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) fire_ready = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_thr(input int t);
    tick();
    tick();
    thr       = t;
    threshold = t[15:0];
  endtask

  // Reference: plain saturating integer arithmetic per neuron, fires in event order.
  task automatic model_event(input int a, input int w);
    int s;
    s = ch[a] + w;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (s >= thr) begin
      ch[a] = 0;
      exp_fire_q.push_back(a);
    end else begin
      ch[a] = s;
    end
  endtask

  task automatic model_clear();
    foreach (ch[i]) ch[i] = 0;
  endtask

  task automatic send(input int a, input int w);
    int n;
    n         = 0;
    in_valid  = 1'b1;
    in_addr   = a[7:0];
    in_weight = w[7:0];
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: in_ready got 0 required 1 (addr %0d)", a);
    end else begin
      model_event(a, w);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_clear_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (clear_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, clear_busy, 0);
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_clear_done("clear_done");
    model_clear();
  endtask

  task automatic compare_fires(input string name);
    int n;
    check({name, "_fire_count"}, fire_q.size(), exp_fire_q.size());
    n = (fire_q.size() < exp_fire_q.size()) ? fire_q.size() : exp_fire_q.size();
    for (int i = 0; i < n; i++) check({name, "_fire_addr"}, fire_q[i], exp_fire_q[i]);
    fire_q.delete();
    exp_fire_q.delete();
  endtask

  vec_t vecs [12];

  initial begin
    int n, nf, bad;
    vecs[0]  = '{5,   40,  100,  40, 1'b0};
    vecs[1]  = '{5,   40,  100,  80, 1'b0};
    vecs[2]  = '{5,   40,  100,   0, 1'b1};
    vecs[3]  = '{7,    1, 1000,   1, 1'b0};
    vecs[4]  = '{8,    1, 1000,   1, 1'b0};
    vecs[5]  = '{7,    1, 1000,   2, 1'b0};
    vecs[6]  = '{8,    1, 1000,   2, 1'b0};
    vecs[7]  = '{11,   1, 1000,   1, 1'b0};
    vecs[8]  = '{11,   1, 1000,   2, 1'b0};
    vecs[9]  = '{11,   1, 1000,   3, 1'b0};
    vecs[10] = '{30, -10,   -5, -10, 1'b0};
    vecs[11] = '{30,   5,   -5,   0, 1'b1};

    // Reset with in_valid held high.
    reset = 1'b1; clear = 1'b0; fire_ready = 1'b1;
    in_valid = 1'b1; in_addr = 8'd0; in_weight = 8'd0;
    thr = 100; threshold = 16'd100;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_fire_valid", fire_valid, 0);
    check("rst_wr_en", ram_wr_en, 0);
    check("rst_rd_en", ram_rd_en, 0);
    check("rst_clear_busy", clear_busy, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      check("sweep_vec", {in_ready, ram_wr_en, clear_busy, ram_wr_addr, ram_wr_data},
            {1'b0, 1'b1, 1'b1, i[7:0], 16'd0});
    end
    @(negedge clk);
    check("sweep_end_in_ready", in_ready, 1);
    check("sweep_end_busy", clear_busy, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_event(0, 0);
    tick();
    tick();

    // Table-driven vectors: accumulation, forwarding, signed threshold boundary.
    log_en = 1'b1;
    foreach (vecs[i]) begin
      if (vecs[i].thr != thr) set_thr(vecs[i].thr);
      send(vecs[i].addr, vecs[i].weight);
    end
    repeat (3) tick();
    log_en = 1'b0;
    check("tbl_write_count", wl_addr.size(), 12);
    foreach (vecs[i]) begin
      if (i < wl_addr.size()) begin
        check("tbl_wr_addr", wl_addr[i], vecs[i].addr);
        check("tbl_wr_data", wl_data[i], vecs[i].exp_wdata);
      end
    end
    nf = 0;
    foreach (vecs[i]) begin
      if (vecs[i].exp_fire) begin
        check("tbl_fire_addr", (nf < fire_q.size()) ? fire_q[nf] : -1, vecs[i].addr);
        nf++;
      end
    end
    check("tbl_fire_count", fire_q.size(), nf);
    fire_q.delete();
    exp_fire_q.delete();
    wl_addr.delete();
    wl_data.delete();

    // Positive saturation: fires exactly when the clamp reaches 32767.
    do_clear();
    set_thr(32767);
    for (int i = 0; i < 300; i++) send(9, 127);
    repeat (3) tick();
    compare_fires("sat_pos");
    check("sat_pos_charge", mem[9], ch[9]);

    // Negative saturation: clamps at -32768 and never wraps positive.
    do_clear();
    log_en = 1'b1;
    for (int i = 0; i < 300; i++) send(9, -128);
    repeat (3) tick();
    log_en = 1'b0;
    bad = 0;
    foreach (wl_data[i]) if (wl_data[i] > 0) bad++;
    check("sat_neg_writes", wl_data.size(), 300);
    check("sat_neg_no_wrap", bad, 0);
    check("sat_neg_charge", mem[9], -32768);
    compare_fires("sat_neg");
    wl_addr.delete();
    wl_data.delete();

    // Stall: held fire blocks the second fire's write and all intake.
    set_thr(10);
    fire_ready = 1'b0;
    send(1, 20);
    send(2, 20);
    fork
      send(3, 20);
      begin
        repeat (4) begin
          @(negedge clk);
          check("stall_vec", {in_ready, ram_wr_en, ram_rd_en, fire_valid, fire_addr},
                {1'b0, 1'b0, 1'b0, 1'b1, 8'd1});
        end
        @(posedge clk);
        #1;
        fire_ready = 1'b1;
      end
    join
    repeat (4) tick();
    compare_fires("stall");
    for (int a = 1; a <= 3; a++) check("stall_charge", mem[a], ch[a]);

    // Clear while an event sits in stage 1: its write lands before the sweep.
    set_thr(1000);
    send(20, 5);
    clear = 1'b1;
    @(negedge clk);
    check("clr_s1_write", {ram_wr_en, ram_wr_addr, ram_wr_data}, {1'b1, 8'd20, 16'd5});
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("clr_pending_busy", clear_busy, 1);
    check("clr_pending_ready", in_ready, 0);
    n = 0;
    while (!(ram_wr_en && ram_wr_addr == 8'd0) && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 256; i++) begin
      check("clr_sweep_vec", {ram_wr_en, clear_busy, in_ready, ram_wr_addr, ram_wr_data},
            {1'b1, 1'b1, 1'b0, i[7:0], 16'd0});
      @(negedge clk);
    end
    check("clr_done_busy", clear_busy, 0);
    check("clr_done_ready", in_ready, 1);
    tick();
    model_clear();
    send(20, 3);
    repeat (3) tick();
    check("clr_reread", mem[20], ch[20]);

    // Clear pulse during a sweep restarts it at address 0.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (40) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    check("clr_restart_addr", {ram_wr_en, ram_wr_addr}, {1'b1, 8'd0});
    wait_clear_done("clr_restart_done");
    model_clear();

    // Randomized events with random back-pressure.
    set_thr(150);
    rand_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      send($urandom_range(0, 7), int'($urandom_range(0, 200)) - 80);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_ready = 1'b0;
    fire_ready = 1'b1;
    repeat (6) tick();
    compare_fires("rand");
    for (int a = 0; a < 256; a++) check("rand_charge", mem[a], ch[a]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
